dds_phase_gen: RTL and testbench
================================

DDS_PHASE_GEN -- requirements
Module: dds_phase_gen

Interface
REQ-001 Parameter N_CH, default 2: number of independent phase channels (1..8).
REQ-002 Parameter PHASE_W, default 14: accumulator and phase output width.
REQ-003 Parameter MODULUS, default 10000: phase wrap value, 2 <= MODULUS <= 2^PHASE_W.
REQ-004 Parameter COMMIT_ON_WRAP, default 0: 1 = defer commit until the channel-0 wrap.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  accumulate enable; when low, accumulators hold.
REQ-008 cfg_valid  in  1  config write request.
REQ-009 cfg_ready  out  1  config write accepted when high with cfg_valid.
REQ-010 cfg_ch  in  max(1,clog2(N_CH))  target channel.
REQ-011 cfg_sel  in  1  0 = tuning word (FTW), 1 = phase offset.
REQ-012 cfg_data  in  PHASE_W  value to write into the shadow register.
REQ-013 cfg_err  out  1  one-cycle pulse: write rejected (cfg_data >= MODULUS or cfg_ch >= N_CH).
REQ-014 commit  in  1  pulse: copy all shadow FTW/offset to active registers.
REQ-015 commit_pend  out  1  high while a deferred commit waits for the wrap.
REQ-016 phase_sync  in  1  pulse: zero all accumulators coherently.
REQ-017 phase_out  out  N_CH*PHASE_W  registered phase per channel; channel k in bits [k*PHASE_W +: PHASE_W].
REQ-018 wrap  out  N_CH  registered one-cycle pulse per channel on accumulator wrap.

Function
REQ-019 Accumulator update when en=1: s = acc + ftw_active (PHASE_W+1 bits); acc_next = s - MODULUS if s >= MODULUS, else s.
REQ-020 wrap[k] SHALL be high in the cycle after the update in which s >= MODULUS, aligned with the corresponding phase_out.
REQ-021 phase_out[k] = (acc + offset_active) mod MODULUS, computed with one conditional subtract and registered; latency 1 cycle from acc.
REQ-022 Write handshake: a write occurs on cfg_valid & cfg_ready; valid writes update only the selected shadow register; invalid writes leave state unchanged and pulse cfg_err the next cycle.
REQ-023 COMMIT_ON_WRAP=0: commit SHALL make new active values effective for the accumulator update in the following cycle; cfg_ready stays high.
REQ-024 COMMIT_ON_WRAP=1: FSM IDLE -> PEND on commit; PEND -> IDLE in the cycle where channel 0 produces s >= MODULUS, applying shadows at that edge; in PEND cfg_ready=0, commit_pend=1, further commit pulses are ignored.
REQ-025 With en=0 in PEND, the FSM SHALL remain in PEND indefinitely.
REQ-026 phase_sync: all accumulators SHALL load 0 at the next edge, overriding en and the update; no wrap pulse is generated.
REQ-027 phase_sync together with commit: accumulators load 0 and commit applies immediately regardless of COMMIT_ON_WRAP; the FSM returns to IDLE.
REQ-028 A write and a commit in the same cycle: the write lands in the shadow; the commit copies the pre-write shadow.
REQ-029 FTW=0 SHALL hold phase constant; FTW=MODULUS-1 SHALL wrap every cycle except from 0.

Reset
REQ-030 rst SHALL clear acc, the active and shadow FTW/offset, phase_out, wrap, and cfg_err; FSM -> IDLE; cfg_ready=1; commit_pend=0.
REQ-031 rst SHALL take priority over every other input, including mid-PEND and mid-handshake; the write is dropped.

Structure
REQ-032 Package dds_pkg SHALL hold default parameter constants (PHASE_W, MODULUS) and the commit FSM state enum.
REQ-033 Sub-module dds_phase_channel SHALL contain one channel's accumulator, active/shadow registers, and output stage; N_CH instances are generated.

Verification
REQ-034 N_CH=2, FTW0=3000, commit, en=1: phase_out0 = 3000, 6000, 9000, 2000 with wrap0=1 on 2000, then 5000.
REQ-035 Offset1=9500, FTW1=1000: phase_out1 = 500, 1500, ..., matching (acc+9500) mod 10000.
REQ-036 Write cfg_data=10000 -> cfg_err pulse; the shadow and subsequent phase are unchanged.
REQ-037 COMMIT_ON_WRAP=1, FTW0=3000 running, new FTW0=100 committed at acc=3000: commit_pend=1 and cfg_ready=0 until the 9000->2000 wrap; the step is 100 afterwards.
REQ-038 phase_sync together with commit at arbitrary phase: both accumulators 0 next cycle, new FTWs active, no wrap pulse.
REQ-039 rst asserted in PEND with cfg_valid high: all outputs 0, cfg_ready=1, and no write is stored.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS phase generator.
//   DEF_PHASE_W    : default accumulator / phase output width
//   DEF_MODULUS    : default phase wrap value
//   commit_state_e : state of the deferred-commit FSM
//   ch_w()         : channel-select width for a given channel count
package dds_pkg;

    localparam int DEF_PHASE_W = 14;
    localparam int DEF_MODULUS = 10000;

    typedef enum logic {
        ST_IDLE = 1'b0,  // shadows copy to active as soon as commit is seen
        ST_PEND = 1'b1   // commit accepted, waiting for the channel-0 wrap
    } commit_state_e;

    // A single-channel build still needs a 1-bit select so the port exists.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dds_phase_gen_if.sv
// Configuration write bus of the DDS phase generator.
//   cfg_valid : write request               (master -> slave)
//   cfg_ch    : target channel              (master -> slave)
//   cfg_sel   : 0 = tuning word, 1 = offset (master -> slave)
//   cfg_data  : value for the shadow reg    (master -> slave)
//   cfg_ready : write accepted with valid   (slave -> master)
//   cfg_err   : one-cycle reject pulse      (slave -> master)
interface dds_phase_gen_if #(
    parameter int N_CH    = 2,
    parameter int PHASE_W = dds_pkg::DEF_PHASE_W
);
    import dds_pkg::*;

    localparam int CH_W = ch_w(N_CH);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch;
    logic               cfg_sel;
    logic [PHASE_W-1:0] cfg_data;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_sel, cfg_data,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_sel, cfg_data,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/dds_phase_channel.sv
// One DDS phase channel: modulo accumulator, shadow/active tuning word and
// offset registers, and the registered phase/wrap output stage.
//   clk, rst   : clock, synchronous active-high reset
//   en         : advance the accumulator
//   phase_sync : load the accumulator with 0 (overrides en)
//   wr_ftw     : write wr_data into the shadow tuning word
//   wr_off     : write wr_data into the shadow offset
//   wr_data    : shadow write value (already range checked)
//   apply      : copy both shadows into the active registers
//   phase      : (acc + offset) mod MODULUS, registered
//   wrap       : wrap pulse, aligned with the phase sample it belongs to
//   upd_wrap   : this cycle's update wraps (drives the commit FSM)
module dds_phase_channel
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_sync,
    input  logic               wr_ftw,
    input  logic               wr_off,
    input  logic [PHASE_W-1:0] wr_data,
    input  logic               apply,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic               upd_wrap
);

    // One extra bit: MODULUS may equal 2^PHASE_W, and acc + ftw < 2*MODULUS.
    localparam logic [PHASE_W:0] MOD_X = (PHASE_W+1)'(MODULUS);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] ftw_act;
    logic [PHASE_W-1:0] off_act;
    logic [PHASE_W-1:0] ftw_sh;
    logic [PHASE_W-1:0] off_sh;
    logic [PHASE_W:0]   sum;
    logic [PHASE_W:0]   psum;
    logic [PHASE_W-1:0] acc_next;
    logic [PHASE_W-1:0] phase_next;
    logic               wrap_d;

    // Both operands are already below MODULUS, so a single conditional
    // subtract is a full modulo reduction.
    // NOTE: every output of an always_comb is assigned on every path; a
    // missing assignment would infer a latch.
    always_comb begin
        sum        = {1'b0, acc} + {1'b0, ftw_act};
        upd_wrap   = en && !phase_sync && (sum >= MOD_X);
        acc_next   = (sum >= MOD_X) ? PHASE_W'(sum - MOD_X) : PHASE_W'(sum);
        psum       = {1'b0, acc} + {1'b0, off_act};
        phase_next = (psum >= MOD_X) ? PHASE_W'(psum - MOD_X) : PHASE_W'(psum);
    end

    // The wrap flag goes through two stages so it lines up with the phase
    // sample showing the wrapped accumulator (phase lags acc by one cycle).
    // Apply copies the shadows before the write lands, so a write and a
    // commit in the same cycle commit the previous shadow contents.
    // NOTE: non-blocking assignments throughout: every register samples the
    // pre-edge value of every other, which is what makes the same-cycle
    // write/commit ordering above come out right.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ftw_act <= '0;
            off_act <= '0;
            ftw_sh  <= '0;
            off_sh  <= '0;
            phase   <= '0;
            wrap_d  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            if (phase_sync) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc_next;
            end
            wrap_d <= upd_wrap;
            wrap   <= wrap_d;
            phase  <= phase_next;
            if (apply) begin
                ftw_act <= ftw_sh;
                off_act <= off_sh;
            end
            if (wr_ftw) begin
                ftw_sh <= wr_data;
            end
            if (wr_off) begin
                off_sh <= wr_data;
            end
        end
    end

endmodule

// File: rtl/dds_phase_gen.sv
// Multi-channel DDS phase generator with shadowed configuration and an
// optional commit deferred to the channel-0 wrap for glitch-free retuning.
//   clk, rst    : clock, synchronous active-high reset
//   en          : accumulate enable
//   cfg         : configuration write bus (slave side)
//   commit      : copy all shadows to the active registers
//   commit_pend : a deferred commit is waiting for the channel-0 wrap
//   phase_sync  : zero all accumulators coherently
//   phase_out   : channel k at [k*PHASE_W +: PHASE_W]
//   wrap        : per-channel wrap pulse, aligned with phase_out
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int N_CH           = 2,
    parameter int PHASE_W        = DEF_PHASE_W,
    parameter int MODULUS        = DEF_MODULUS,
    parameter int COMMIT_ON_WRAP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      commit,
    input  logic                      phase_sync,
    dds_phase_gen_if.slave            cfg,
    output logic                      commit_pend,
    output logic [N_CH*PHASE_W-1:0]   phase_out,
    output logic [N_CH-1:0]           wrap
);

    localparam int               CH_W   = ch_w(N_CH);
    localparam logic [PHASE_W:0] MOD_X  = (PHASE_W+1)'(MODULUS);
    localparam logic [CH_W:0]    CH_LIM = (CH_W+1)'(N_CH);

    commit_state_e   state;
    commit_state_e   state_next;
    logic            wr_fire;
    logic            wr_ok;
    logic            apply;
    logic            cfg_err_q;
    logic [N_CH-1:0] upd_wrap;
    logic            unused_upd_wrap;

    // Writes are refused outside IDLE so a pending commit cannot pick up
    // half of a new configuration.
    assign cfg.cfg_ready = (state == ST_IDLE);
    assign commit_pend   = (state == ST_PEND);
    assign cfg.cfg_err   = cfg_err_q;

    assign wr_fire = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_ok   = wr_fire
                     && ({1'b0, cfg.cfg_data} < MOD_X)
                     && ({1'b0, cfg.cfg_ch} < CH_LIM);

    // Only channel 0 paces the deferred commit.
    assign unused_upd_wrap = ^upd_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_next;
            cfg_err_q <= wr_fire && !wr_ok;
        end
    end

    // A sync+commit always applies at once: the accumulators restart from
    // zero anyway, so there is no wrap worth waiting for.
    always_comb begin
        state_next = state;
        apply      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit) begin
                    if ((COMMIT_ON_WRAP == 0) || phase_sync) begin
                        apply = 1'b1;
                    end else begin
                        state_next = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if ((commit && phase_sync) || upd_wrap[0]) begin
                    apply      = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic hit;

        assign hit = wr_ok && (cfg.cfg_ch == CH_W'(k));

        dds_phase_channel #(
            .PHASE_W (PHASE_W),
            .MODULUS (MODULUS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .phase_sync (phase_sync),
            .wr_ftw     (hit && !cfg.cfg_sel),
            .wr_off     (hit && cfg.cfg_sel),
            .wr_data    (cfg.cfg_data),
            .apply      (apply),
            .phase      (phase_out[k*PHASE_W +: PHASE_W]),
            .wrap       (wrap[k]),
            .upd_wrap   (upd_wrap[k])
        );
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Bench for dds_phase_gen: two instances (immediate and wrap-deferred
// commit) share one directed stimulus stream. A cycle-level model written
// in modulo arithmetic predicts every output; literal tables pin the model.
module tb_dds_phase_gen;
    import dds_pkg::*;

    localparam int N_CH = 3;
    localparam int PW   = 14;
    localparam int MOD  = 10000;

    logic          clk;
    logic          rst;
    logic          en;
    logic          commit;
    logic          phase_sync;
    logic          cfg_valid;
    logic [1:0]    cfg_ch;
    logic          cfg_sel;
    logic [PW-1:0] cfg_data;

    logic [N_CH*PW-1:0] po     [2];
    logic [N_CH-1:0]    wr_a   [2];
    logic               pend_a [2];
    logic               rdy_a  [2];
    logic               err_a  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model state, index [instance][channel]; instance 1 defers commits.
    int m_acc  [2][N_CH];
    int m_ftw  [2][N_CH];
    int m_off  [2][N_CH];
    int m_sftw [2][N_CH];
    int m_soff [2][N_CH];
    bit m_pipe [2][N_CH];
    bit m_pend [2];
    int e_phase[2][N_CH];
    bit e_wrap [2][N_CH];
    bit e_err  [2];

    int p0_tab [6] = '{0, 3000, 6000, 9000, 2000, 5000};
    int p1_tab [6] = '{9500, 500, 1500, 2500, 3500, 4500};
    int w0_tab [6] = '{0, 0, 0, 0, 1, 0};

    dds_phase_gen_if #(.N_CH(N_CH), .PHASE_W(PW)) cfg0 ();
    dds_phase_gen_if #(.N_CH(N_CH), .PHASE_W(PW)) cfg1 ();

    assign cfg0.cfg_valid = cfg_valid;
    assign cfg0.cfg_ch    = cfg_ch;
    assign cfg0.cfg_sel   = cfg_sel;
    assign cfg0.cfg_data  = cfg_data;
    assign cfg1.cfg_valid = cfg_valid;
    assign cfg1.cfg_ch    = cfg_ch;
    assign cfg1.cfg_sel   = cfg_sel;
    assign cfg1.cfg_data  = cfg_data;
    assign rdy_a[0] = cfg0.cfg_ready;
    assign rdy_a[1] = cfg1.cfg_ready;
    assign err_a[0] = cfg0.cfg_err;
    assign err_a[1] = cfg1.cfg_err;

    dds_phase_gen #(.N_CH(N_CH), .PHASE_W(PW), .MODULUS(MOD), .COMMIT_ON_WRAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .commit(commit), .phase_sync(phase_sync),
        .cfg(cfg0), .commit_pend(pend_a[0]), .phase_out(po[0]), .wrap(wr_a[0])
    );

    dds_phase_gen #(.N_CH(N_CH), .PHASE_W(PW), .MODULUS(MOD), .COMMIT_ON_WRAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .commit(commit), .phase_sync(phase_sync),
        .cfg(cfg1), .commit_pend(pend_a[1]), .phase_out(po[1]), .wrap(wr_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of behaviour for instance m, from the inputs sampled at the edge.
    task automatic model_step(input int m);
        bit was_pend;
        bit fire;
        bit ok;
        bit apply;
        bit wrapping [N_CH];
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                m_acc[m][k] = 0;  m_ftw[m][k] = 0;  m_off[m][k] = 0;
                m_sftw[m][k] = 0; m_soff[m][k] = 0; m_pipe[m][k] = 0;
                e_phase[m][k] = 0; e_wrap[m][k] = 0;
            end
            m_pend[m] = 0;
            e_err[m]  = 0;
            return;
        end
        was_pend = m_pend[m];
        fire = cfg_valid && !was_pend;
        ok   = (int'(cfg_data) < MOD) && (int'(cfg_ch) < N_CH);
        for (int k = 0; k < N_CH; k++) begin
            wrapping[k]   = en && !phase_sync && (m_acc[m][k] + m_ftw[m][k] >= MOD);
            e_phase[m][k] = (m_acc[m][k] + m_off[m][k]) % MOD;
            e_wrap[m][k]  = m_pipe[m][k];
            m_pipe[m][k]  = wrapping[k];
        end
        apply = 0;
        if (commit && (m == 0 || phase_sync)) begin
            apply = 1; m_pend[m] = 0;
        end else if (was_pend && wrapping[0]) begin
            apply = 1; m_pend[m] = 0;
        end else if (commit) begin
            m_pend[m] = 1;
        end
        for (int k = 0; k < N_CH; k++) begin
            if (phase_sync)  m_acc[m][k] = 0;
            else if (en)     m_acc[m][k] = (m_acc[m][k] + m_ftw[m][k]) % MOD;
            if (apply) begin
                m_ftw[m][k] = m_sftw[m][k];
                m_off[m][k] = m_soff[m][k];
            end
        end
        if (fire && ok) begin
            if (cfg_sel) m_soff[m][cfg_ch] = int'(cfg_data);
            else         m_sftw[m][cfg_ch] = int'(cfg_data);
        end
        e_err[m] = fire && !ok;
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] phase_of(input int m, input int k);
        return 32'(po[m][k*PW +: PW]);
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("dut%0d_phase%0d", m, k), phase_of(m, k), 32'(e_phase[m][k]));
                check($sformatf("dut%0d_wrap%0d", m, k), 32'(wr_a[m][k]), 32'(e_wrap[m][k]));
            end
            check($sformatf("dut%0d_cfg_err", m), 32'(err_a[m]), 32'(e_err[m]));
            check($sformatf("dut%0d_cfg_ready", m), 32'(rdy_a[m]), 32'(!m_pend[m]));
            check($sformatf("dut%0d_commit_pend", m), 32'(pend_a[m]), 32'(m_pend[m]));
        end
    endtask

    // Advance one clock; outputs are compared on the following falling edge.
    task automatic step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [1:0] ch, input logic sel, input logic [PW-1:0] data);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_sel   = sel;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; commit = 1'b0; phase_sync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
        step();
        step();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_phase_dut%0d", m), phase_of(m, 0), 32'd0);
            check($sformatf("rst_ready_dut%0d", m), 32'(rdy_a[m]), 32'd1);
            check($sformatf("rst_pend_dut%0d", m), 32'(pend_a[m]), 32'd0);
        end
        rst = 1'b0;

        // Basic tuning: ch0 step 3000, ch1 step 1000 with offset 9500, ch2 step M-1.
        wr(2'd0, 1'b0, 14'd3000);
        wr(2'd1, 1'b0, 14'd1000);
        wr(2'd1, 1'b1, 14'd9500);
        wr(2'd2, 1'b0, 14'd9999);
        en = 1'b1; commit = 1'b1; phase_sync = 1'b1;
        step();
        commit = 1'b0; phase_sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                check($sformatf("seq%0d_p0_dut%0d", i, m), phase_of(m, 0), 32'(p0_tab[i]));
                check($sformatf("seq%0d_p1_dut%0d", i, m), phase_of(m, 1), 32'(p1_tab[i]));
                check($sformatf("seq%0d_w0_dut%0d", i, m), 32'(wr_a[m][0]), 32'(w0_tab[i]));
            end
        end

        // Rejected writes: out-of-range data, then out-of-range channel.
        wr(2'd0, 1'b0, 14'd10000);
        check("err_data_dut0", 32'(err_a[0]), 32'd1);
        check("err_data_dut1", 32'(err_a[1]), 32'd1);
        step();
        check("err_clear_dut0", 32'(err_a[0]), 32'd0);
        wr(2'd3, 1'b0, 14'd5);
        check("err_ch_dut0", 32'(err_a[0]), 32'd1);

        // Deferred commit: new ch0 step 100 committed while acc0 = 3000.
        wr(2'd0, 1'b0, 14'd100);
        phase_sync = 1'b1;
        step();
        phase_sync = 1'b0;
        step();
        commit = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_sel = 1'b0; cfg_data = 14'd2000;
        step();
        check("pend_after_commit", 32'(pend_a[1]), 32'd1);
        check("ready_in_pend", 32'(rdy_a[1]), 32'd0);
        cfg_ch = 2'd2; cfg_sel = 1'b1; cfg_data = 14'd1234;
        step();
        commit = 1'b0; cfg_valid = 1'b0;
        check("pend_holds", 32'(pend_a[1]), 32'd1);
        step();
        check("pend_released", 32'(pend_a[1]), 32'd0);
        check("ready_released", 32'(rdy_a[1]), 32'd1);
        check("phase_pre_wrap", phase_of(1, 0), 32'd9000);
        step();
        check("phase_wrap", phase_of(1, 0), 32'd2000);
        check("wrap_flag", 32'(wr_a[1][0]), 32'd1);
        step();
        check("new_step_1", phase_of(1, 0), 32'd2100);
        step();
        check("new_step_2", phase_of(1, 0), 32'd2200);

        // Pending commit with en low never resolves on its own.
        wr(2'd0, 1'b0, 14'd250);
        en = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (5) step();
        check("pend_en_low", 32'(pend_a[1]), 32'd1);

        // Sync together with commit: immediate apply, accumulators zeroed.
        en = 1'b1; commit = 1'b1; phase_sync = 1'b1;
        step();
        commit = 1'b0; phase_sync = 1'b0;
        check("sync_commit_idle", 32'(pend_a[1]), 32'd0);
        step();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("sync_p0_dut%0d", m), phase_of(m, 0), 32'd0);
            check($sformatf("sync_p1_dut%0d", m), phase_of(m, 1), 32'd9500);
            check($sformatf("sync_wrap_dut%0d", m), 32'(wr_a[m]), 32'd0);
        end
        step();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("sync_step_dut%0d", m), phase_of(m, 0), 32'd250);
        end

        // Reset while pending and mid-write: write dropped, all cleared.
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("pend_before_rst", 32'(pend_a[1]), 32'd1);
        rst = 1'b1; commit = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_data = 14'd777;
        step();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < N_CH; k++) begin
                check($sformatf("rst_mid_p%0d_dut%0d", k, m), phase_of(m, k), 32'd0);
            end
            check($sformatf("rst_mid_wrap_dut%0d", m), 32'(wr_a[m]), 32'd0);
            check($sformatf("rst_mid_ready_dut%0d", m), 32'(rdy_a[m]), 32'd1);
            check($sformatf("rst_mid_pend_dut%0d", m), 32'(pend_a[m]), 32'd0);
        end
        rst = 1'b0; cfg_valid = 1'b0; commit = 1'b1; phase_sync = 1'b1;
        step();
        commit = 1'b0; phase_sync = 1'b0;
        repeat (3) step();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("no_write_stored_dut%0d", m), phase_of(m, 0), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
